// File: rtl/param_code_lock.sv
// Sequence code lock: collects CODE_LEN symbols, compares them against a programmable code,
// and handles open hold, failure counting, timed lockout, entry timeout and in-field code change.
module param_code_lock #(
   parameter int SYM_W       = 3,
   parameter int CODE_LEN    = 3,
   parameter logic [SYM_W*CODE_LEN-1:0] DEFAULT_CODE = 9'b011111101,
   parameter int OPEN_CYC    = 16,
   parameter int MAX_FAIL    = 3,
   parameter int LOCKOUT_CYC = 1024,
   parameter int ENTRY_TO    = 256
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sym_valid,
   input  logic [SYM_W-1:0]              sym,
   input  logic                          code_wr,
   input  logic [SYM_W*CODE_LEN-1:0]     code_in,
   output logic                          unlock,
   output logic                          fail,
   output logic                          locked_out,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

   localparam int T_OL  = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
   localparam int T_MAX = (T_OL > ENTRY_TO) ? T_OL : ENTRY_TO;
   localparam int TMR_W = $clog2(T_MAX + 1);
   localparam int FC_W  = $clog2(MAX_FAIL + 1);
   localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

   typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

   state_t                      state, state_n;
   logic [SYM_W*CODE_LEN-1:0]   code, code_n;
   logic [IDX_W-1:0]            idx, idx_n;
   logic                        match, match_n;
   logic [TMR_W-1:0]            timer, timer_n;
   logic [FC_W-1:0]             fail_cnt_n, fc_inc;
   logic                        fail_n;
   logic [SYM_W-1:0]            cur_sym;
   logic                        sym_hit, last, timer_done, eval, eval_ok, run_match;

   always_comb begin
      cur_sym = '0;
      for (int i = 0; i < CODE_LEN; i++)
         if (idx == IDX_W'(i)) cur_sym = code[(CODE_LEN-1-i)*SYM_W +: SYM_W];
   end

   assign sym_hit    = (sym == cur_sym);
   assign last       = (idx == IDX_W'(CODE_LEN - 1));
   assign timer_done = (timer == TMR_W'(1));
   // match holds 1 in IDLE, so the first symbol starts a fresh AND-chain
   assign run_match  = match & sym_hit;
   assign fc_inc     = (fail_cnt == FC_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FC_W'(1);

   always_comb begin
      state_n    = state;
      code_n     = code;
      idx_n      = idx;
      match_n    = match;
      timer_n    = timer;
      fail_cnt_n = fail_cnt;
      fail_n     = 1'b0;
      eval       = 1'b0;
      eval_ok    = 1'b0;
      case (state)
         IDLE, ENTRY: begin
            if (sym_valid) begin
               if (last) begin
                  eval    = 1'b1;
                  eval_ok = run_match;
               end else begin
                  state_n = ENTRY;
                  idx_n   = idx + IDX_W'(1);
                  match_n = run_match;
                  timer_n = TMR_W'(ENTRY_TO);
               end
            end else if (state == ENTRY) begin
               // idle too long: drop the partial entry without counting a failure
               if (timer_done) begin
                  state_n = IDLE;
                  idx_n   = '0;
                  match_n = 1'b1;
                  timer_n = '0;
               end else begin
                  timer_n = timer - TMR_W'(1);
               end
            end
         end
         OPEN: begin
            if (code_wr) code_n = code_in;
            if (timer_done) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         LOCKOUT: begin
            if (timer_done) begin
               state_n    = IDLE;
               timer_n    = '0;
               fail_cnt_n = '0;
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      if (eval) begin
         idx_n   = '0;
         match_n = 1'b1;
         if (eval_ok) begin
            state_n    = OPEN;
            timer_n    = TMR_W'(OPEN_CYC);
            fail_cnt_n = '0;
         end else begin
            fail_n     = 1'b1;
            fail_cnt_n = fc_inc;
            if (fc_inc == FC_W'(MAX_FAIL)) begin
               state_n = LOCKOUT;
               timer_n = TMR_W'(LOCKOUT_CYC);
            end else begin
               state_n = IDLE;
               timer_n = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         code       <= DEFAULT_CODE;
         idx        <= '0;
         match      <= 1'b1;
         timer      <= '0;
         fail_cnt   <= '0;
         unlock     <= 1'b0;
         fail       <= 1'b0;
         locked_out <= 1'b0;
      end else begin
         state      <= state_n;
         code       <= code_n;
         idx        <= idx_n;
         match      <= match_n;
         timer      <= timer_n;
         fail_cnt   <= fail_cnt_n;
         unlock     <= (state_n == OPEN);
         fail       <= fail_n;
         locked_out <= (state_n == LOCKOUT);
      end
   end

endmodule

// File: tb/tb_param_code_lock.sv
// Directed self-checking bench for param_code_lock with default parameters.
module tb_param_code_lock;

   logic       clk = 1'b0;
   logic       reset;
   logic       sym_valid;
   logic [2:0] sym;
   logic       code_wr;
   logic [8:0] code_in;
   logic       unlock, fail, locked_out;
   logic [1:0] fail_cnt;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int fail_seen = 0;

   param_code_lock dut (
      .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym(sym),
      .code_wr(code_wr), .code_in(code_in), .unlock(unlock), .fail(fail),
      .locked_out(locked_out), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (fail === 1'b1) fail_seen <= fail_seen + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send(input logic [2:0] s);
      sym = s; sym_valid = 1'b1;
      @(posedge clk); #1;
      sym_valid = 1'b0;
   endtask

   task automatic send3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      send(a); send(b); send(c);
   endtask

   task automatic test_reset;
      reset = 1'b1; sym_valid = 1'b0; sym = '0; code_wr = 1'b0; code_in = '0;
      #12;
      total++; if ({unlock, fail, locked_out, fail_cnt} !== 5'b0) begin bad++;
         $display("FAIL reset_outs: got %b want 00000", {unlock, fail, locked_out, fail_cnt}); end
      @(negedge clk); reset = 1'b0;
      tick(2);
      total++; if ({unlock, fail, locked_out, fail_cnt} !== 5'b0) begin bad++;
         $display("FAIL post_reset_outs: got %b want 00000", {unlock, fail, locked_out, fail_cnt}); end
   endtask

   task automatic test_defaults;
      int n = 0;
      int f0 = fail_seen;
      send3(3'd3, 3'd7, 3'd5);
      while (unlock === 1'b1 && n < 100) begin n++; tick(1); end
      total++; if (n !== 16) begin bad++;
         $display("FAIL open_len: got %0d want 16", n); end
      total++; if (fail_seen !== f0) begin bad++;
         $display("FAIL open_no_fail: got %0d want %0d", fail_seen, f0); end
      total++; if (fail_cnt !== 2'd0) begin bad++;
         $display("FAIL open_fail_cnt: got %0d want 0", fail_cnt); end
   endtask

   task automatic test_wrong_first;
      int f0 = fail_seen;
      send(3'd2); send(3'd7);
      total++; if (fail !== 1'b0) begin bad++;
         $display("FAIL no_early_abort: got %b want 0", fail); end
      send(3'd5);
      total++; if ({fail, unlock, fail_cnt} !== 4'b1001) begin bad++;
         $display("FAIL wrong_eval: got %b want 1001", {fail, unlock, fail_cnt}); end
      tick(1);
      total++; if (fail !== 1'b0 || fail_seen - f0 !== 1) begin bad++;
         $display("FAIL fail_pulse_len: got fail=%b pulses=%0d want 0/1", fail, fail_seen - f0); end
   endtask

   task automatic test_lockout;
      int c0, c1;
      int g = 0;
      send3(3'd2, 3'd7, 3'd5);
      total++; if (fail_cnt !== 2'd2 || locked_out !== 1'b0) begin bad++;
         $display("FAIL second_fail: got cnt=%0d lo=%b want 2/0", fail_cnt, locked_out); end
      send3(3'd1, 3'd1, 3'd1);
      c0 = cyc;
      total++; if (locked_out !== 1'b1 || fail_cnt !== 2'd3) begin bad++;
         $display("FAIL lockout_enter: got lo=%b cnt=%0d want 1/3", locked_out, fail_cnt); end
      send3(3'd3, 3'd7, 3'd5);
      total++; if (unlock !== 1'b0) begin bad++;
         $display("FAIL lockout_ignores: got %b want 0", unlock); end
      while (locked_out === 1'b1 && g < 2000) begin g++; tick(1); end
      c1 = cyc;
      total++; if (c1 - c0 !== 1024) begin bad++;
         $display("FAIL lockout_len: got %0d want 1024", c1 - c0); end
      total++; if (fail_cnt !== 2'd0) begin bad++;
         $display("FAIL lockout_clear: got %0d want 0", fail_cnt); end
      send3(3'd3, 3'd7, 3'd5);
      total++; if (unlock !== 1'b1) begin bad++;
         $display("FAIL after_lockout_open: got %b want 1", unlock); end
      tick(16);
   endtask

   task automatic test_timeout;
      int f0;
      send3(3'd0, 3'd0, 3'd0);
      f0 = fail_seen + 1;
      total++; if (fail_cnt !== 2'd1) begin bad++;
         $display("FAIL to_setup: got %0d want 1", fail_cnt); end
      send(3'd3); send(3'd7); tick(256); send(3'd5);
      total++; if ({unlock, fail, fail_cnt} !== 4'b0001) begin bad++;
         $display("FAIL timeout_discard: got %b want 0001", {unlock, fail, fail_cnt}); end
      tick(256);
      total++; if (fail_seen !== f0 || fail_cnt !== 2'd1) begin bad++;
         $display("FAIL timeout_no_count: got pulses=%0d cnt=%0d want %0d/1", fail_seen, fail_cnt, f0); end
      send(3'd3); send(3'd7); tick(255); send(3'd5);
      total++; if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin bad++;
         $display("FAIL timeout_edge_open: got u=%b cnt=%0d want 1/0", unlock, fail_cnt); end
      tick(16);
   endtask

   task automatic test_reprogram;
      send3(3'd3, 3'd7, 3'd5);
      tick(15);
      total++; if (unlock !== 1'b1) begin bad++;
         $display("FAIL last_open_cycle: got %b want 1", unlock); end
      code_wr = 1'b1; code_in = 9'b001010100;
      tick(1);
      code_wr = 1'b0;
      total++; if (unlock !== 1'b0) begin bad++;
         $display("FAIL open_end: got %b want 0", unlock); end
      send3(3'd3, 3'd7, 3'd5);
      total++; if (fail !== 1'b1 || fail_cnt !== 2'd1) begin bad++;
         $display("FAIL old_code_rejected: got f=%b cnt=%0d want 1/1", fail, fail_cnt); end
      send3(3'd1, 3'd2, 3'd4);
      total++; if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin bad++;
         $display("FAIL new_code_open: got u=%b cnt=%0d want 1/0", unlock, fail_cnt); end
      tick(16);
      code_wr = 1'b1; code_in = 9'b111111111;
      tick(1);
      code_wr = 1'b0;
      send3(3'd7, 3'd7, 3'd7);
      total++; if (fail !== 1'b1) begin bad++;
         $display("FAIL idle_wr_ignored: got %b want 1", fail); end
      send3(3'd1, 3'd2, 3'd4);
      total++; if (unlock !== 1'b1) begin bad++;
         $display("FAIL code_kept: got %b want 1", unlock); end
      tick(16);
   endtask

   task automatic test_reset_mid_open;
      send3(3'd1, 3'd2, 3'd4);
      tick(3);
      #2 reset = 1'b1;
      #1;
      total++; if (unlock !== 1'b0) begin bad++;
         $display("FAIL async_reset: got %b want 0", unlock); end
      @(negedge clk); reset = 1'b0;
      send3(3'd3, 3'd7, 3'd5);
      total++; if (unlock !== 1'b1) begin bad++;
         $display("FAIL default_restored: got %b want 1", unlock); end
   endtask

   initial begin
      test_reset;
      test_defaults;
      test_wrong_first;
      test_lockout;
      test_timeout;
      test_reprogram;
      test_reset_mid_open;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
